// File: rtl/serial_mod_reduce.sv
// serial_mod_reduce: bit-serial restoring reduction of a WIDTH_IN-bit product
// modulo a WIDTH_M-bit modulus. One product bit is consumed per cycle, MSB
// first, so one operation takes WIDTH_IN cycles. Ready/valid handshake on both
// sides; only one operation is in flight at any time.
module serial_mod_reduce #(
    parameter int WIDTH_IN = 384,
    parameter int WIDTH_M  = 128,
    parameter int CNT_W    = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH_IN-1:0] p_in,
    input  logic [WIDTH_M-1:0]  m_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH_M-1:0]  r_out,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH_IN-1:0] r_p_sh;      // product, shifted left one bit per RUN cycle
    logic [WIDTH_M-1:0]  r_m;         // modulus captured at accept
    logic [WIDTH_M-1:0]  r_rem;       // running remainder, always < r_m
    logic [CNT_W-1:0]    r_cnt;       // product bits consumed so far
    logic                r_in_ready;
    logic                r_out_valid;
    logic [WIDTH_M-1:0]  r_r_out;
    logic                r_err;

    logic [WIDTH_M:0]    w_t;         // remainder with next product bit appended
    logic [WIDTH_M:0]    w_m_ext;
    logic [WIDTH_M:0]    w_diff;
    logic                w_ge;
    logic [WIDTH_M-1:0]  w_rem_next;
    logic                w_last;

    assign w_t     = {r_rem, r_p_sh[WIDTH_IN-1]};
    assign w_m_ext = {1'b0, r_m};
    assign w_ge    = (w_t >= w_m_ext);
    assign w_diff  = w_t - w_m_ext;

    // With r < m we have t <= 2m-1, so one conditional subtract restores
    // r < m and both candidates fit in WIDTH_M bits (t < m implies t's MSB is 0).
    assign w_rem_next = w_ge ? w_diff[WIDTH_M-1:0] : w_t[WIDTH_M-1:0];

    // Last RUN cycle: this edge consumes the final product bit.
    assign w_last = (r_cnt == CNT_W'(WIDTH_IN - 1));

    // Control FSM and datapath: accept, shift/subtract WIDTH_IN times, hold result until hand-off.
    // NOTE: every register here uses non-blocking assignment so all of them
    // sample pre-edge values; blocking would let r_rem see its own update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_p_sh      <= '0;
            r_m         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_r_out     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_p_sh     <= p_in;
                        r_m        <= m_in;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (m_in == '0) begin
                            // Division by zero: report immediately, skip the RUN phase.
                            r_r_out     <= '0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    r_rem  <= w_rem_next;
                    r_p_sh <= r_p_sh << 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_r_out     <= w_rem_next;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign r_out     = r_r_out;
    assign err       = r_err;

endmodule
